mandelbrot_iter: RTL and testbench
==================================

# mandelbrot_iter

Per-pixel Mandelbrot escape-time engine that produces the iteration count consumed by the colour lookup stage. It accepts one complex coordinate c over a valid/ready handshake and iterates z = z² + c in signed fixed point, one iteration per clock. It returns the escape iteration, saturated to `MAX_ITERATION-1` so the result is always a legal colour-table index. It sits between the pixel coordinate generator and the iteration→RGB lookup.

## Interface
- `DATA_WIDTH`, 32: width of coordinates, z registers and iteration count.
- `FRAC_BITS`, 24: fractional bits of the signed fixed-point format (Q8.24 at default); must satisfy `FRAC_BITS <= DATA_WIDTH-4`.
- `MAX_ITERATION`, 256: colour-table depth; must satisfy `2 <= MAX_ITERATION <= 2^DATA_WIDTH`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  c_re/c_im valid.
- `in_ready`  out  1  engine idle, can accept c.
- `c_re`  in  DATA_WIDTH  signed fixed-point real part of c.
- `c_im`  in  DATA_WIDTH  signed fixed-point imaginary part of c.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `iterations`  out  DATA_WIDTH  escape iteration, 0..MAX_ITERATION-1.
- `escaped`  out  1  1 = escaped; 0 = hit iteration cap.

## Operation
- FSM states IDLE, ITER, DONE; reset state IDLE.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `iterations`=0, `escaped`=0, z_re=z_im=0, internal count=0.
- IDLE: `in_ready`=1. Accept on `in_valid && in_ready`: latch c_re/c_im, z←0, k←0, go ITER.
- ITER, per cycle, on current z_k with count k:
  - m = z_re² + z_im², full precision (2·DATA_WIDTH+1 bits, 2·FRAC_BITS fractional).
  - If m > 4.0 (strictly; i.e. m > 4<<(2·FRAC_BITS)): iterations←k, escaped←1, go DONE.
  - Else if k == MAX_ITERATION-1: iterations←k, escaped←0, go DONE.
  - Else: z_re←trunc(z_re² − z_im²)+c_re; z_im←trunc(2·z_re·z_im)+c_im; k←k+1.
- trunc: full 2·DATA_WIDTH-bit signed product, arithmetic shift right FRAC_BITS (round toward −∞), keep low DATA_WIDTH bits. The addition with c wraps modulo 2^DATA_WIDTH. No saturation.
- Escape test always uses the un-truncated squares, so detection is exact for any z representable in DATA_WIDTH.
- DONE: `out_valid`=1; `iterations` and `escaped` held stable until `out_valid && out_ready`, then go IDLE. `in_ready`=0 in ITER and DONE; one coordinate in flight at a time.
- `in_valid` is ignored outside IDLE. c is not re-sampled after acceptance.
- Reset asserted in any state aborts the computation. No result is emitted, and the state returns to the reset values on that edge.

## Timing
- Accept at edge T → ITER cycles at edges T+1 … T+N+1 (N = final `iterations`) → `out_valid` high after edge T+N+1. Latency is N+1 cycles, max MAX_ITERATION.
- Result consumed at edge U (out_valid && out_ready) → `in_ready` high after U. The earliest next accept is edge U+1, giving a throughput of one result per N+3 cycles minimum.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready` to any output.
- Downstream stall: DONE is held indefinitely with outputs frozen.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `iterations`=0, `escaped`=0, `in_ready`=1; nothing accepted.
- c=3.0 (c_re=0x03000000, c_im=0) → `iterations`=1, `escaped`=1, `out_valid` 2 cycles after accept. c=2.0 (0x02000000) → `iterations`=2, `escaped`=1. This checks that m == 4.0 does not escape.
- Cap: c=0 and c=−2.0 (0xFE000000) → `iterations`=255, `escaped`=0, `out_valid` exactly 256 cycles after accept.
- Imaginary path: c=(0, 2.0) (c_im=0x02000000) → z1=2i, z2=−4+2i → `iterations`=2, `escaped`=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → outputs stable, `in_ready`=0, a new `in_valid` is ignored; `out_ready`=1 → `in_ready`=1 next cycle, and the next c is accepted and computed correctly.
- Reset mid-ITER: c=0, assert `rst_n`=0 at cycle 50 for 1 cycle → no `out_valid`, `in_ready`=1 after reset. The next c=3.0 yields `iterations`=1.

Source files
------------

// File: rtl/mandelbrot_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_iter_if
//  Purpose  : Handshake bundle between the pixel coordinate generator, the
//             Mandelbrot escape-time engine and the colour lookup stage.
//  Signals  : in_valid/in_ready + c_re/c_im  (coordinate request)
//             out_valid/out_ready + iterations/escaped (result)
//  Modports : master - coordinate producer / result consumer
//             slave  - the iteration engine
//  Revision : 1.0  initial release
// ============================================================================
interface mandelbrot_iter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] c_re;
    logic [DATA_WIDTH-1:0] c_im;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] iterations;
    logic                  escaped;

    modport master (
        output in_valid, c_re, c_im, out_ready,
        input  in_ready, out_valid, iterations, escaped
    );

    modport slave (
        input  in_valid, c_re, c_im, out_ready,
        output in_ready, out_valid, iterations, escaped
    );
endinterface
`default_nettype wire

// File: rtl/mandelbrot_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mandelbrot_iter
//  Purpose  : Per-pixel escape-time engine. Accepts c, iterates z = z^2 + c
//             in signed fixed point at one iteration per clock, and returns
//             the escape iteration (capped at MAX_ITERATION-1).
//  Ports    : clk   - sole clock, rising edge
//             rst_n - synchronous active-low reset
//             bus   - mandelbrot_iter_if.slave (coordinate in, result out)
//  Revision : 1.0  initial release
// ============================================================================
module mandelbrot_iter #(
    parameter int     DATA_WIDTH    = 32,
    parameter int     FRAC_BITS     = 24,
    parameter longint MAX_ITERATION = 256
) (
    input wire               clk,
    input wire               rst_n,
    mandelbrot_iter_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam int W2 = 2 * DATA_WIDTH;

    // Escape threshold 4.0 expressed with 2*FRAC_BITS fractional bits.
    localparam logic signed [W2:0]         c_FOUR  = (W2+1)'(4) << (2 * FRAC_BITS);
    localparam logic [DATA_WIDTH-1:0]      c_K_MAX = DATA_WIDTH'(MAX_ITERATION - 1);

    logic [1:0]                   r_state;
    logic signed [DATA_WIDTH-1:0] r_c_re;
    logic signed [DATA_WIDTH-1:0] r_c_im;
    logic signed [DATA_WIDTH-1:0] r_z_re;
    logic signed [DATA_WIDTH-1:0] r_z_im;
    logic [DATA_WIDTH-1:0]        r_k;
    logic [DATA_WIDTH-1:0]        r_iterations;
    logic                         r_escaped;

    logic signed [W2-1:0]         w_sq_re;
    logic signed [W2-1:0]         w_sq_im;
    logic signed [W2-1:0]         w_cross;
    logic signed [W2:0]           w_mag;
    logic signed [W2:0]           w_diff;
    logic signed [W2:0]           w_cross2;
    logic signed [DATA_WIDTH-1:0] w_z_re_next;
    logic signed [DATA_WIDTH-1:0] w_z_im_next;
    logic                         w_escape;

    // Full-precision products; the magnitude uses the untruncated squares so
    // the escape decision is exact for every representable z.
    always_comb begin
        w_sq_re  = r_z_re * r_z_re;
        w_sq_im  = r_z_im * r_z_im;
        w_cross  = r_z_re * r_z_im;
        w_mag    = (W2+1)'(w_sq_re) + (W2+1)'(w_sq_im);
        w_diff   = (W2+1)'(w_sq_re) - (W2+1)'(w_sq_im);
        w_cross2 = (W2+1)'(w_cross) <<< 1;
        w_escape = (w_mag > c_FOUR);
        // Arithmetic shift floors toward -inf; the narrowing cast keeps the
        // low DATA_WIDTH bits and the add with c wraps by design.
        w_z_re_next = DATA_WIDTH'(w_diff   >>> FRAC_BITS) + r_c_re;
        w_z_im_next = DATA_WIDTH'(w_cross2 >>> FRAC_BITS) + r_c_im;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_c_re       <= '0;
            r_c_im       <= '0;
            r_z_re       <= '0;
            r_z_im       <= '0;
            r_k          <= '0;
            r_iterations <= '0;
            r_escaped    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_c_re  <= bus.c_re;
                        r_c_im  <= bus.c_im;
                        r_z_re  <= '0;
                        r_z_im  <= '0;
                        r_k     <= '0;
                        r_state <= c_ITER;
                    end
                end
                c_ITER: begin
                    if (w_escape) begin
                        r_iterations <= r_k;
                        r_escaped    <= 1'b1;
                        r_state      <= c_DONE;
                    end else if (r_k == c_K_MAX) begin
                        r_iterations <= r_k;
                        r_escaped    <= 1'b0;
                        r_state      <= c_DONE;
                    end else begin
                        r_z_re <= w_z_re_next;
                        r_z_im <= w_z_im_next;
                        r_k    <= r_k + 1'b1;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign bus.in_ready   = (r_state == c_IDLE);
    assign bus.out_valid  = (r_state == c_DONE);
    assign bus.iterations = r_iterations;
    assign bus.escaped    = r_escaped;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mandelbrot_iter
//  Purpose  : Directed self-checking bench for mandelbrot_iter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mandelbrot_iter;

    localparam logic [31:0] c_THREE   = 32'h0300_0000;
    localparam logic [31:0] c_TWO     = 32'h0200_0000;
    localparam logic [31:0] c_NEG_TWO = 32'hFE00_0000;
    localparam logic [31:0] c_ZERO    = 32'h0000_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mandelbrot_iter_if #(.DATA_WIDTH(32)) bus ();

    mandelbrot_iter #(
        .DATA_WIDTH    (32),
        .FRAC_BITS     (24),
        .MAX_ITERATION (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present c until the engine takes it; ok=0 if it never became ready.
    task automatic accept(input logic [31:0] re, input logic [31:0] im, output bit ok);
        int n;
        n = 0;
        bus.c_re     = re;
        bus.c_im     = im;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        ok = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen.
    task automatic wait_result(output int lat, output bit ok);
        lat = 0;
        while (!bus.out_valid && lat < 400) begin
            tick();
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.c_re     = c_THREE;
        bus.c_im     = c_ZERO;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.iterations !== 32'd0) begin errors++; $display("FAIL reset_iterations: got %0d want 0", bus.iterations); end
        checks++; if (bus.escaped !== 1'b0) begin errors++; $display("FAIL reset_escaped: got %b want 0", bus.escaped); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_nothing_accepted: in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_escape_real();
        bit ok;
        int lat;
        accept(c_THREE, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL c3_timeout: out_valid got 0 want 1"); end
        checks++; if (bus.iterations !== 32'd1) begin errors++; $display("FAIL c3_iterations: got %0d want 1", bus.iterations); end
        checks++; if (bus.escaped !== 1'b1) begin errors++; $display("FAIL c3_escaped: got %b want 1", bus.escaped); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL c3_latency: got %0d want 2", lat); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL c3_in_ready_after: got %b want 1", bus.in_ready); end

        accept(c_TWO, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd2) begin errors++; $display("FAIL c2_iterations: got %0d want 2", bus.iterations); end
        checks++; if (bus.escaped !== 1'b1) begin errors++; $display("FAIL c2_escaped: got %b want 1", bus.escaped); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL c2_latency: got %0d want 3", lat); end
        tick();
    endtask

    task automatic test_cap();
        bit ok;
        int lat;
        accept(c_ZERO, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd255) begin errors++; $display("FAIL cap0_iterations: got %0d want 255", bus.iterations); end
        checks++; if (bus.escaped !== 1'b0) begin errors++; $display("FAIL cap0_escaped: got %b want 0", bus.escaped); end
        checks++; if (lat !== 256) begin errors++; $display("FAIL cap0_latency: got %0d want 256", lat); end
        tick();

        accept(c_NEG_TWO, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd255) begin errors++; $display("FAIL capm2_iterations: got %0d want 255", bus.iterations); end
        checks++; if (bus.escaped !== 1'b0) begin errors++; $display("FAIL capm2_escaped: got %b want 0", bus.escaped); end
        checks++; if (lat !== 256) begin errors++; $display("FAIL capm2_latency: got %0d want 256", lat); end
        tick();
    endtask

    task automatic test_imag();
        bit ok;
        int lat;
        accept(c_ZERO, c_TWO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd2) begin errors++; $display("FAIL imag_iterations: got %0d want 2", bus.iterations); end
        checks++; if (bus.escaped !== 1'b1) begin errors++; $display("FAIL imag_escaped: got %b want 1", bus.escaped); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL imag_latency: got %0d want 3", lat); end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        bus.out_ready = 1'b0;
        accept(c_THREE, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: out_valid got 0 want 1"); end
        bus.in_valid = 1'b1;
        bus.c_re     = c_TWO;
        bus.c_im     = c_ZERO;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            checks++; if (bus.iterations !== 32'd1 || bus.escaped !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got iter=%0d esc=%b want iter=1 esc=1", i, bus.iterations, bus.escaped);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b want 0", bus.out_valid); end
        accept(c_TWO, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd2 || bus.escaped !== 1'b1) begin
            errors++; $display("FAIL bp_next: got iter=%0d esc=%b want iter=2 esc=1", bus.iterations, bus.escaped);
        end
        tick();
    endtask

    task automatic test_reset_mid_iter();
        bit ok;
        int lat;
        bit seen;
        accept(c_ZERO, c_ZERO, ok);
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result: out_valid seen=%b want 0", seen); end
        accept(c_THREE, c_ZERO, ok);
        wait_result(lat, ok);
        checks++; if (bus.iterations !== 32'd1 || bus.escaped !== 1'b1) begin
            errors++; $display("FAIL midrst_next: got iter=%0d esc=%b want iter=1 esc=1", bus.iterations, bus.escaped);
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_latency: got %0d want 2", lat); end
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.c_re      = '0;
        bus.c_im      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_escape_real();
        test_cap();
        test_imag();
        test_backpressure();
        test_reset_mid_iter();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
